input_conditioner: RTL



---
 rtl/input_conditioner.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/input_conditioner.sv
// ---------------------------------------------------------------------------
// input_conditioner
//
// Purpose:
//    Per-channel conditioning for raw asynchronous button and pad inputs.
//    Each channel is brought into the clock domain by a two-flop synchronizer.
//    A counter then debounces it. The result is a stable level plus registered
//    single-cycle rise and fall strobes. An optional auto-repeat generator
//    emits periodic strobes while a channel is held high.
//
// Configuration macro:
//    INPUT_COND_REPEAT_EN - when defined, the repeat FSM and hold counters
//                           are built. When undefined, repeat_pulse is tied
//                           to 0 and the REPEAT_* parameters are ignored.
//
// Parameters:
//    CHANNELS        - number of independent input channels
//    DEBOUNCE_CYCLES - consecutive stable cycles needed to accept a change (>= 1)
//    REPEAT_DELAY    - cycles from rise strobe to first repeat strobe (>= 1)
//    REPEAT_PERIOD   - cycles between later repeat strobes (>= 1)
//
// Ports:
//    clock        in   sole clock, rising edge
//    reset        in   synchronous active-low reset
//    raw_in       in   [CHANNELS] asynchronous raw inputs, active-high
//    level_out    out  [CHANNELS] debounced level
//    rise_pulse   out  [CHANNELS] one-cycle strobe on accepted 0->1
//    fall_pulse   out  [CHANNELS] one-cycle strobe on accepted 1->0
//    repeat_pulse out  [CHANNELS] one-cycle auto-repeat strobe while held
// ---------------------------------------------------------------------------
module input_conditioner #(
   parameter int CHANNELS        = 5,
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter int REPEAT_DELAY    = 25000000,
   parameter int REPEAT_PERIOD   = 5000000
) (
   input  logic                clock,
   input  logic                reset,
   input  logic [CHANNELS-1:0] raw_in,
   output logic [CHANNELS-1:0] level_out,
   output logic [CHANNELS-1:0] rise_pulse,
   output logic [CHANNELS-1:0] fall_pulse,
   output logic [CHANNELS-1:0] repeat_pulse
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic [CHANNELS-1:0] sync1_q;
   logic [CHANNELS-1:0] sync2_q;
   logic [CHANNELS-1:0] level_q;
   logic [CHANNELS-1:0] level_d;
   logic [CHANNELS-1:0] rise_q;
   logic [CHANNELS-1:0] rise_d;
   logic [CHANNELS-1:0] fall_q;
   logic [CHANNELS-1:0] fall_d;
   logic [CW-1:0]       cnt_q [CHANNELS];
   logic [CW-1:0]       cnt_d [CHANNELS];

   // Debounce decision for every channel. The counter only advances while
   // the synchronized input disagrees with the accepted level. Any agreement
   // clears it, so a glitch throws away all progress. At the terminal count
   // the new level is taken and exactly one strobe fires. Rise or fall is
   // chosen by the direction of the change.
   always_comb begin
      level_d = level_q;
      rise_d  = '0;
      fall_d  = '0;
      for (int ch = 0; ch < CHANNELS; ch++) begin
         cnt_d[ch] = '0;
         if (sync2_q[ch] != level_q[ch]) begin
            if (cnt_q[ch] == CNT_LAST) begin
               level_d[ch] = sync2_q[ch];
               rise_d[ch]  = sync2_q[ch];
               fall_d[ch]  = ~sync2_q[ch];
            end else begin
               cnt_d[ch] = cnt_q[ch] + 1'b1;
            end
         end
      end
   end

   // Synchronizer, accepted level, counters and strobes. Reset is sampled on
   // the clock edge. It clears the synchronizer too, so an input held high
   // through reset is seen as a brand-new change afterwards.
   always_ff @(posedge clock) begin
      if (!reset) begin
         sync1_q <= '0;
         sync2_q <= '0;
         level_q <= '0;
         rise_q  <= '0;
         fall_q  <= '0;
         for (int ch = 0; ch < CHANNELS; ch++) begin
            cnt_q[ch] <= '0;
         end
      end else begin
         sync1_q <= raw_in;
         sync2_q <= sync1_q;
         level_q <= level_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
         for (int ch = 0; ch < CHANNELS; ch++) begin
            cnt_q[ch] <= cnt_d[ch];
         end
      end
   end

   assign level_out  = level_q;
   assign rise_pulse = rise_q;
   assign fall_pulse = fall_q;

`ifdef INPUT_COND_REPEAT_EN

   typedef enum logic [1:0] {
      REP_IDLE,
      REP_DELAY,
      REP_REPEAT
   } repState_t;

   localparam int HOLD_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int HW = $clog2(HOLD_MAX + 1);
   localparam logic [HW-1:0] DELAY_LAST  = HW'(REPEAT_DELAY - 1);
   localparam logic [HW-1:0] PERIOD_LAST = HW'(REPEAT_PERIOD - 1);

   repState_t           repState_q [CHANNELS];
   repState_t           repState_d [CHANNELS];
   logic [HW-1:0]       hcnt_q [CHANNELS];
   logic [HW-1:0]       hcnt_d [CHANNELS];
   logic [CHANNELS-1:0] repeat_q;
   logic [CHANNELS-1:0] repeat_d;

   // Repeat FSM next-state logic. The FSM reacts to the debounce decision
   // being made on this same edge (rise_d / level_d) and not to the
   // registered strobes. This lines the first repeat up exactly REPEAT_DELAY
   // cycles after the rise strobe. The hold checks level_d, so a fall that is
   // accepted on a repeat slot still suppresses that repeat strobe.
   always_comb begin
      repeat_d = '0;
      for (int ch = 0; ch < CHANNELS; ch++) begin
         repState_d[ch] = repState_q[ch];
         hcnt_d[ch]     = hcnt_q[ch];
         case (repState_q[ch])
            REP_IDLE: begin
               hcnt_d[ch] = '0;
               if (rise_d[ch]) begin
                  repState_d[ch] = REP_DELAY;
               end
            end
            REP_DELAY: begin
               if (!level_d[ch]) begin
                  repState_d[ch] = REP_IDLE;
                  hcnt_d[ch]     = '0;
               end else if (hcnt_q[ch] == DELAY_LAST) begin
                  repeat_d[ch]   = 1'b1;
                  hcnt_d[ch]     = '0;
                  repState_d[ch] = REP_REPEAT;
               end else begin
                  hcnt_d[ch] = hcnt_q[ch] + 1'b1;
               end
            end
            REP_REPEAT: begin
               if (!level_d[ch]) begin
                  repState_d[ch] = REP_IDLE;
                  hcnt_d[ch]     = '0;
               end else if (hcnt_q[ch] == PERIOD_LAST) begin
                  repeat_d[ch] = 1'b1;
                  hcnt_d[ch]   = '0;
               end else begin
                  hcnt_d[ch] = hcnt_q[ch] + 1'b1;
               end
            end
            default: begin
               repState_d[ch] = REP_IDLE;
               hcnt_d[ch]     = '0;
            end
         endcase
      end
   end

   // Repeat state, hold counters and the registered repeat strobe.
   always_ff @(posedge clock) begin
      if (!reset) begin
         repeat_q <= '0;
         for (int ch = 0; ch < CHANNELS; ch++) begin
            repState_q[ch] <= REP_IDLE;
            hcnt_q[ch]     <= '0;
         end
      end else begin
         repeat_q <= repeat_d;
         for (int ch = 0; ch < CHANNELS; ch++) begin
            repState_q[ch] <= repState_d[ch];
            hcnt_q[ch]     <= hcnt_d[ch];
         end
      end
   end

   assign repeat_pulse = repeat_q;

`else

   assign repeat_pulse = '0;

`endif

endmodule
